// File: rtl/stack_multi_sequencer.sv
// Multi-register push/pop sequencer: walks a register mask, adjusting the stack
// pointer through the register file and moving data over a req/ack memory port.
module stack_multi_sequencer #(
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 4,
   parameter int REG_COUNT   = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   op,
   input  logic [INDEX_WIDTH-1:0] sp_index,
   input  logic [REG_COUNT-1:0]   reg_mask,
   output logic                   busy,
   output logic                   done,
   output logic                   rf_write,
   output logic [INDEX_WIDTH-1:0] rf_write_index,
   output logic [DATA_WIDTH-1:0]  rf_write_data,
   output logic                   rf_inc,
   output logic                   rf_dec,
   output logic [INDEX_WIDTH-1:0] rf_incdec_index,
   output logic [INDEX_WIDTH-1:0] rf_read_a_index,
   input  logic [DATA_WIDTH-1:0]  rf_read_a_data,
   output logic [INDEX_WIDTH-1:0] rf_read_b_index,
   input  logic [DATA_WIDTH-1:0]  rf_read_b_data,
   output logic                   mem_req,
   output logic                   mem_write,
   output logic [DATA_WIDTH-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0]  mem_wdata,
   input  logic [DATA_WIDTH-1:0]  mem_rdata,
   input  logic                   mem_ack
);

   typedef enum logic [2:0] {StIdle, StDecSp, StMemWr, StMemRd, StDone} state_t;

   state_t                 state_q, state_d;
   logic                   op_q, op_d;
   logic [INDEX_WIDTH-1:0] sp_q, sp_d;
   logic [REG_COUNT-1:0]   mask_q, mask_d;
   logic [INDEX_WIDTH-1:0] cur;
   logic [REG_COUNT-1:0]   mask_clr;
   logic [REG_COUNT-1:0]   eff_mask;

   // SP is never part of the transfer set.
   assign eff_mask = reg_mask & ~(REG_COUNT'(1) << sp_index);
   assign mask_clr = mask_q & ~(REG_COUNT'(1) << cur);

   assign rf_incdec_index = sp_q;
   assign rf_read_a_index = sp_q;
   assign rf_read_b_index = cur;

   // Priority encode: highest remaining bit for push, lowest for pop.
   always_comb begin
      cur = '0;
      if (op_q) begin
         for (int i = REG_COUNT - 1; i >= 0; i--) begin
            if (mask_q[i]) cur = INDEX_WIDTH'(i);
         end
      end else begin
         for (int i = 0; i < REG_COUNT; i++) begin
            if (mask_q[i]) cur = INDEX_WIDTH'(i);
         end
      end
   end

   // State and operand registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         op_q    <= 1'b0;
         sp_q    <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sp_q    <= sp_d;
         mask_q  <= mask_d;
      end
   end

   // Next-state and outputs; everything is forced quiet while reset is high so
   // no partial transfer or SP step lands on the reset edge.
   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      sp_d           = sp_q;
      mask_d         = mask_q;
      busy           = 1'b0;
      done           = 1'b0;
      rf_write       = 1'b0;
      rf_write_index = '0;
      rf_write_data  = '0;
      rf_inc         = 1'b0;
      rf_dec         = 1'b0;
      mem_req        = 1'b0;
      mem_write      = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      if (!reset) begin
         busy = (state_q != StIdle);
         case (state_q)
            StIdle: begin
               if (start) begin
                  op_d   = op;
                  sp_d   = sp_index;
                  mask_d = eff_mask;
                  if (eff_mask == '0) state_d = StDone;
                  else if (op)        state_d = StMemRd;
                  else                state_d = StDecSp;
               end
            end
            StDecSp: begin
               rf_dec  = 1'b1;
               state_d = StMemWr;
            end
            StMemWr: begin
               mem_req   = 1'b1;
               mem_write = 1'b1;
               mem_addr  = rf_read_a_data;
               mem_wdata = rf_read_b_data;
               if (mem_ack) begin
                  mask_d  = mask_clr;
                  state_d = (mask_clr != '0) ? StDecSp : StDone;
               end
            end
            StMemRd: begin
               mem_req  = 1'b1;
               mem_addr = rf_read_a_data;
               if (mem_ack) begin
                  rf_write       = 1'b1;
                  rf_write_index = cur;
                  rf_write_data  = mem_rdata;
                  rf_inc         = 1'b1;
                  mask_d         = mask_clr;
                  state_d        = (mask_clr != '0) ? StMemRd : StDone;
               end
            end
            StDone: begin
               done    = 1'b1;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

endmodule

// File: doc/stack_multi_sequencer.md
Name: stack_multi_sequencer

Overview:
Sequences multi-register push and pop between the register file and the data memory bus. Given a 16-bit register mask and a stack-pointer register index, it drives the register file's write, inc and dec controls and two read ports, together with a req/ack memory port. It sits beside register_file in the execute stage and is started by the instruction decoder.

Parameters:
DATA_WIDTH, 32, width of register and memory data and addresses
INDEX_WIDTH, 4, register index width
REG_COUNT, 16, number of registers and mask width

Ports:
clock  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin an operation; sampled only in IDLE
op  in  1  0 = push, 1 = pop
sp_index  in  INDEX_WIDTH  register used as the stack pointer
reg_mask  in  REG_COUNT  bit n set = transfer register rn
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in the DONE state
rf_write  out  1  register file write enable
rf_write_index  out  INDEX_WIDTH  register file write index
rf_write_data  out  DATA_WIDTH  register file write data
rf_inc  out  1  register file inc-by-4 enable
rf_dec  out  1  register file dec-by-4 enable
rf_incdec_index  out  INDEX_WIDTH  register file inc/dec index; always equals the latched SP index
rf_read_a_index  out  INDEX_WIDTH  read port A index; always the latched SP index
rf_read_a_data  in  DATA_WIDTH  current SP value (combinational read)
rf_read_b_index  out  INDEX_WIDTH  read port B index; the current register
rf_read_b_data  in  DATA_WIDTH  current register value
mem_req  out  1  bus request
mem_write  out  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  out  DATA_WIDTH  bus address
mem_wdata  out  DATA_WIDTH  bus write data
mem_rdata  in  DATA_WIDTH  bus read data; valid in the cycle mem_ack is high
mem_ack  in  1  transfer complete; sampled at the edge while mem_req is high

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. At the reset edge the block enters IDLE and all outputs go to 0, including busy, done, mem_req and the rf_* strobes.
- States: IDLE, DEC_SP, MEM_WR, MEM_RD, DONE.
- IDLE:
  - start=1 latches op, sp_index and an effective mask, defined as reg_mask with bit sp_index cleared (the SP is never transferred).
  - Next state: DONE if the effective mask is zero; otherwise DEC_SP for a push, MEM_RD for a pop.
  - start=0 keeps the block in IDLE.
- Push ordering: descending, highest set bit first. For the current register cur:
  - DEC_SP (1 cycle): rf_dec=1.
  - MEM_WR: mem_req=1, mem_write=1, mem_addr=rf_read_a_data (the SP value after the decrement), mem_wdata=rf_read_b_data with read_b index cur. Held until mem_ack.
  - On mem_ack: clear bit cur. Next state is DEC_SP if bits remain, else DONE.
- Pop ordering: ascending, lowest set bit first. For the current register cur:
  - MEM_RD: mem_req=1, mem_write=0, mem_addr=rf_read_a_data. Held until mem_ack.
  - In the mem_ack cycle, assert together: rf_write=1, rf_write_index=cur, rf_write_data=mem_rdata, and rf_inc=1. The register file applies the write and the increment at the same edge.
  - After that edge: clear bit cur. Next state is MEM_RD if bits remain, else DONE.
- Current register: cur is the priority-encoded highest set bit (push) or lowest set bit (pop) of the remaining mask, taken from registered state.
- DONE: 1 cycle with done=1 and busy=1, then IDLE.
- Strobe hygiene: rf_write, rf_inc, rf_dec and mem_req are 0 in every state and cycle not listed above.
- Latency with zero-wait memory (ack in the first req cycle):
  - push of N registers: 2N cycles, then DONE.
  - pop of N registers: N cycles, then DONE.
  - Each wait cycle extends the current MEM_WR or MEM_RD state by one cycle.
- Bus stability: mem_addr, mem_wdata and mem_write stay stable while mem_req is high and ack has not yet arrived.
- start while busy: ignored, not queued.
- Reset mid-operation: IDLE at the next edge; mem_req drops; the SP keeps whatever partial adjustment has already been applied.
- SP arithmetic: 4-byte steps performed by the register file; 32-bit wrap-around is allowed and not flagged.

Test Plan:
- Push: r15=0x1000, r0=0x11, r2=0x22, start, op=0, sp_index=15, mask=0x0005, zero-wait memory -> write 0x22 to address 0x0FFC, then write 0x11 to 0x0FF8; r15=0x0FF8; done pulses in cycle 5 after start.
- Pop from r15=0x0FF8 with memory [0x0FF8]=0xAA and [0x0FFC]=0xBB, mask=0x0005 -> r0=0xAA, r2=0xBB, r15=0x1000; done in cycle 3 after start.
- Push with 2 wait cycles on each ack, mask=0x0001 -> mem_req held for 3 cycles with address and data stable; done in cycle 5 after start.
- Mask=0x0000, and separately mask=0x8000 with sp_index=15 -> no mem_req, no SP change, done in cycle 1 after start.
- Pop of mask=0x00FF, reset asserted during the third MEM_RD -> IDLE with busy=0 and mem_req=0 at the next edge; r15 advanced by 8; start reasserted during the operation has no effect.
